// File: rtl/ltm_writer_pkg.sv
// ltm_writer_pkg: shared types and register map for the LTM frame writer
package ltm_writer_pkg;
  typedef enum logic [1:0] {IDLE, PT_ADDR, PT_WR, CLR_WR} state_t;
  localparam logic [3:0] REG_BASE   = 4'd0;
  localparam logic [3:0] REG_COLOR  = 4'd1;
  localparam logic [3:0] REG_CTRL   = 4'd2;
  localparam logic [3:0] REG_STATUS = 4'd3;
  localparam logic [3:0] REG_WCNT   = 4'd4;
  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [31:0] colour;
  } pt_t;
endpackage

// File: rtl/ltm_pt_fifo.sv
// ltm_pt_fifo: single-clock point FIFO with full/empty flags
module ltm_pt_fifo
  import ltm_writer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  pt_t  din_i,
  output pt_t  dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  pt_t mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign wr      = push_i && !full_o;
  assign rd      = pop_i && !empty_o;
  assign dout_o  = mem[rp_q];
  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (wr) mem[wp_q] <= din_i;
  end
  // pointers and occupancy; push+pop together leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
      cnt_q <= (wr && !rd) ? cnt_q + 1'b1 : (!wr && rd) ? cnt_q - 1'b1 : cnt_q;
    end
  end
endmodule

// File: rtl/ltm_frame_writer.sv
// ltm_frame_writer: Avalon-MM point/clear writer for the LTM frame buffer; define LTM_WRITER_BOUNDS_CHECK_EN to drop off-screen points
module ltm_frame_writer
  import ltm_writer_pkg::*;
#(
  parameter logic [31:0] ADDRESS_BASE   = 32'h0800_0000,
  parameter int          LTM_width      = 800,
  parameter int          LTM_height     = 480,
  parameter int          WR_BURST       = 64,
  parameter int          CMD_FIFO_DEPTH = 16
) (
  input  logic        csi_clockreset_clk,
  input  logic        csi_clockreset_reset,
  output logic [31:0] avm_m1_address,
  output logic        avm_m1_write,
  output logic [31:0] avm_m1_writedata,
  output logic [3:0]  avm_m1_byteenable,
  output logic [9:0]  avm_m1_burstcount,
  input  logic        avm_m1_waitrequest,
  input  logic [3:0]  avs_s1_address,
  input  logic        avs_s1_write,
  input  logic [31:0] avs_s1_writedata,
  input  logic        avs_s1_read,
  output logic [31:0] avs_s1_readdata,
  input  logic        avm_m1_export_iPtValid,
  input  logic [9:0]  avm_m1_export_iPtX,
  input  logic [9:0]  avm_m1_export_iPtY,
  input  logic [31:0] avm_m1_export_iPtColor,
  output logic        avm_m1_export_oPtReady,
  output logic        avm_m1_export_oBusy
);
  localparam int NBURST = LTM_width * LTM_height / WR_BURST;
  localparam int IW = $clog2(NBURST + 1);
  localparam int BW = $clog2(WR_BURST + 1);
  localparam logic [18:0] W19 = 19'(LTM_width);
  localparam logic [31:0] BSTEP = 32'(WR_BURST * 4);
  logic clk, rst;
  state_t state_q, state_d;
  pt_t pt_in, pt_q, fifo_out;
  logic push, pop, full, empty, accept, clr_start, clr_req, beat_last, burst_last;
  logic clr_pend_q;
  logic [31:0] base_q, col_q, addr_q, data_q, lat_base_q, wr_cnt_q, rd_mux, readdata_q;
  logic [15:0] drop_q;
  logic [IW-1:0] idx_q;
  logic [BW-1:0] beat_q;
  assign clk        = csi_clockreset_clk;
  assign rst        = csi_clockreset_reset;
  assign pt_in      = {avm_m1_export_iPtX, avm_m1_export_iPtY, avm_m1_export_iPtColor};
  assign push       = avm_m1_export_iPtValid && !full;
  assign accept     = !avm_m1_waitrequest;
  assign clr_start  = state_q == IDLE && clr_pend_q;
  assign pop        = state_q == IDLE && !clr_pend_q && !empty;
  assign beat_last  = state_q == CLR_WR && accept && beat_q == BW'(WR_BURST - 1);
  assign burst_last = beat_last && idx_q == IW'(NBURST - 1);
  assign clr_req    = avs_s1_write && avs_s1_address == REG_CTRL && avs_s1_writedata[0] && !clr_pend_q && state_q != CLR_WR;
  assign avm_m1_address    = addr_q;
  assign avm_m1_writedata  = data_q;
  assign avm_m1_byteenable = 4'hF;
  assign avs_s1_readdata   = readdata_q;

  ltm_pt_fifo #(.DEPTH(CMD_FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .din_i(pt_in),
    .dout_o(fifo_out), .full_o(full), .empty_o(empty)
  );

`ifdef LTM_WRITER_BOUNDS_CHECK_EN
  logic oob;
  assign oob = {22'd0, pt_q.x} >= 32'(LTM_width) || {22'd0, pt_q.y} >= 32'(LTM_height);
  // saturating count of off-screen points discarded in PT_ADDR
  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else if (state_q == PT_ADDR && oob && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
  end
`else
  assign drop_q = '0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next state: a pending clear wins over queued points only at IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = clr_pend_q ? CLR_WR : (!empty ? PT_ADDR : IDLE);
`ifdef LTM_WRITER_BOUNDS_CHECK_EN
      PT_ADDR: state_d = oob ? IDLE : PT_WR;
`else
      PT_ADDR: state_d = PT_WR;
`endif
      PT_WR:   state_d = accept ? IDLE : PT_WR;
      CLR_WR:  state_d = burst_last ? IDLE : CLR_WR;
      default: state_d = IDLE;
    endcase
  end

  // bus control outputs decoded from the current state
  always_comb begin
    avm_m1_write           = state_q == PT_WR || state_q == CLR_WR;
    avm_m1_burstcount      = state_q == CLR_WR ? 10'(WR_BURST) : 10'd1;
    avm_m1_export_oBusy    = state_q != IDLE;
    avm_m1_export_oPtReady = !full;
  end

  // register read mux; the control register always reads back 0
  always_comb begin
    rd_mux = '0;
    case (avs_s1_address)
      REG_BASE:   rd_mux = base_q;
      REG_COLOR:  rd_mux = col_q;
      REG_STATUS: rd_mux = {drop_q, 14'd0, clr_pend_q || state_q == CLR_WR, state_q != IDLE};
      REG_WCNT:   rd_mux = wr_cnt_q;
      default:    rd_mux = '0;
    endcase
  end

  // software registers, operation latches, address/data generation and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= ADDRESS_BASE;
      col_q      <= '0;
      clr_pend_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      lat_base_q <= ADDRESS_BASE;
      pt_q       <= '0;
      wr_cnt_q   <= '0;
      idx_q      <= '0;
      beat_q     <= '0;
      readdata_q <= '0;
    end else begin
      if (avs_s1_write && avs_s1_address == REG_BASE) base_q <= avs_s1_writedata;
      if (avs_s1_write && avs_s1_address == REG_COLOR) col_q <= avs_s1_writedata;
      if (clr_req) clr_pend_q <= 1'b1;
      else if (clr_start) clr_pend_q <= 1'b0;
      if (clr_start) begin
        addr_q <= base_q;
        data_q <= col_q;
        idx_q  <= '0;
        beat_q <= '0;
      end
      if (pop) begin
        pt_q       <= fifo_out;
        lat_base_q <= base_q;
        data_q     <= fifo_out.colour;
      end
      if (state_q == PT_ADDR) addr_q <= lat_base_q + {11'd0, 19'(pt_q.y) * W19 + 19'(pt_q.x), 2'b00};
      if (state_q == PT_WR && accept) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (state_q == CLR_WR && accept) begin
        beat_q <= beat_last ? '0 : beat_q + 1'b1;
        if (beat_last) begin
          idx_q  <= idx_q + 1'b1;
          addr_q <= addr_q + BSTEP;
        end
      end
      if (avs_s1_read) readdata_q <= rd_mux;
    end
  end
endmodule

// File: tb/tb_ltm_frame_writer.sv
// tb_ltm_frame_writer: self-checking bench for ltm_frame_writer (frame height reduced to 8 lines to keep the clear short)
module tb_ltm_frame_writer;
  localparam int W = 800, H = 8, B = 64;
  localparam int CLR_TOTAL = W * H;
`ifdef LTM_WRITER_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  typedef struct {logic [31:0] a; logic [31:0] d;} exp_t;
  typedef struct {logic [3:0] a; bit wr; logic [31:0] wd; logic [31:0] exp;} reg_vec_t;
  typedef struct {int x; int y; logic [31:0] c; bit drop; logic [31:0] ea;} pt_vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] m_addr, m_data, s_rdata, s_wdata = '0, p_col = '0;
  logic m_write, m_wait = 1'b0, s_write = 1'b0, s_read = 1'b0, p_valid = 1'b0, p_ready, busy;
  logic [3:0] m_be, s_addr = '0;
  logic [9:0] m_bc, p_x = '0, p_y = '0;

  int checks = 0, passed = 0, beats_total = 0, clr_beats = 0, exp_pts = 0, exp_drop = 0, accepted;
  bit clr_active = 0, force_wait = 0, rand_wait = 0, stall_prev = 0, ok;
  logic [31:0] clr_base, clr_col, prev_a, prev_d, model_base = 32'h0800_0000, r;
  logic [9:0] prev_bc;
  exp_t exp_q[$];
  exp_t e;
  reg_vec_t rv[6];
  pt_vec_t tv[6];

  ltm_frame_writer #(.LTM_height(H)) dut (
    .csi_clockreset_clk(clk), .csi_clockreset_reset(rst),
    .avm_m1_address(m_addr), .avm_m1_write(m_write), .avm_m1_writedata(m_data),
    .avm_m1_byteenable(m_be), .avm_m1_burstcount(m_bc), .avm_m1_waitrequest(m_wait),
    .avs_s1_address(s_addr), .avs_s1_write(s_write), .avs_s1_writedata(s_wdata),
    .avs_s1_read(s_read), .avs_s1_readdata(s_rdata),
    .avm_m1_export_iPtValid(p_valid), .avm_m1_export_iPtX(p_x), .avm_m1_export_iPtY(p_y),
    .avm_m1_export_iPtColor(p_col), .avm_m1_export_oPtReady(p_ready), .avm_m1_export_oBusy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // slave stall generator, updated shortly after every rising edge
  always @(posedge clk) begin
    #2;
    m_wait = force_wait || (rand_wait && $urandom_range(0, 2) == 0);
  end

  // bus monitor: stall stability, clear-beat model and point scoreboard
  always @(negedge clk) begin
    if (rst) stall_prev = 0;
    else begin
      if (stall_prev) begin
        chk("stall_addr", m_addr, prev_a);
        chk("stall_data", m_data, prev_d);
        chk("stall_ctl", {21'd0, m_write, m_bc}, {21'd0, 1'b1, prev_bc});
      end
      if (m_write && !m_wait) begin
        beats_total++;
        if (clr_active && m_bc != 10'd1) begin
          chk("clr_addr", m_addr, clr_base + 32'(clr_beats / B) * (B * 4));
          chk("clr_data", m_data, clr_col);
          chk("clr_bc", 32'(m_bc), B);
          clr_beats++;
        end else begin
          if (clr_active) chk("pt_after_clr", clr_beats, CLR_TOTAL);
          if (exp_q.size() == 0) chk("pt_unexpected", 0, 1);
          else begin
            e = exp_q.pop_front();
            chk("pt_addr", m_addr, e.a);
            chk("pt_data", m_data, e.d);
            chk("pt_bc", 32'(m_bc), 1);
          end
        end
      end
      stall_prev = m_write && m_wait;
      prev_a = m_addr;
      prev_d = m_data;
      prev_bc = m_bc;
    end
  end

  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    s_addr = a; s_wdata = d; s_write = 1;
    @(posedge clk); #1;
    s_write = 0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    s_addr = a; s_read = 1;
    @(posedge clk); #1;
    s_read = 0;
    d = s_rdata;
  endtask

  task automatic send(input int x, input int y, input logic [31:0] c, input int max, output bit acc);
    acc = 0;
    p_x = x[9:0]; p_y = y[9:0]; p_col = c; p_valid = 1;
    for (int i = 0; i < max && !acc; i++) begin
      @(negedge clk);
      if (p_ready) acc = 1;
      @(posedge clk); #1;
    end
    p_valid = 0;
  endtask

  task automatic model_push(input int x, input int y, input logic [31:0] c);
    if (BC && (x >= W || y >= H)) exp_drop++;
    else begin
      exp_q.push_back('{model_base + 32'((y * W + x) * 4), c});
      exp_pts++;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (6) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    rv[0] = '{4'd0, 1'b0, 32'h0, 32'h0800_0000};
    rv[1] = '{4'd1, 1'b1, 32'h1234_5678, 32'h1234_5678};
    rv[2] = '{4'd2, 1'b1, 32'h0, 32'h0};
    rv[3] = '{4'd5, 1'b1, 32'hDEAD_BEEF, 32'h0};
    rv[4] = '{4'd4, 1'b0, 32'h0, 32'h0};
    rv[5] = '{4'd1, 1'b1, 32'h0, 32'h0};
    tv[0] = '{10, 2, 32'h00FF_0000, 1'b0, 32'h0800_1928};
    tv[1] = '{0, 0, 32'h1122_3344, 1'b0, 32'h0800_0000};
    tv[2] = '{799, 7, 32'hCAFE_BABE, 1'b0, 32'h0800_63FC};
    tv[3] = '{5, 1, 32'h0000_FFFF, 1'b0, 32'h0800_0C94};
    tv[4] = '{0, 7, 32'h5A5A_A5A5, 1'b0, 32'h0800_5780};
`ifdef LTM_WRITER_BOUNDS_CHECK_EN
    tv[5] = '{800, 0, 32'h1234_5678, 1'b1, 32'h0};
`else
    tv[5] = '{800, 0, 32'h1234_5678, 1'b0, 32'h0800_0C80};
`endif
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_write", m_write, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_data", m_data, 0);
    chk("rst_bc", 32'(m_bc), 1);
    chk("rst_be", 32'(m_be), 32'hF);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", p_ready, 1);
    for (int i = 0; i < 6; i++) begin
      if (rv[i].wr) reg_wr(rv[i].a, rv[i].wd);
      reg_rd(rv[i].a, r);
      chk($sformatf("reg_vec%0d", i), r, rv[i].exp);
    end
    @(posedge clk); #1;
    s_addr = 4'd0; s_wdata = 32'h1111_0000; s_write = 1; s_read = 1;
    @(posedge clk); #1;
    s_write = 0; s_read = 0;
    chk("rw_same_old", s_rdata, 32'h0800_0000);
    reg_rd(4'd0, r);
    chk("rw_same_new", r, 32'h1111_0000);
    reg_wr(4'd0, 32'h0800_0000);
    send(10, 2, 32'h00FF_0000, 10, ok);
    chk("lat_accept", ok, 1);
    exp_q.push_back('{32'h0800_1928, 32'h00FF_0000});
    exp_pts++;
    chk("lat_n1", m_write, 0);
    @(posedge clk); #1;
    chk("lat_n2", m_write, 0);
    @(posedge clk); #1;
    chk("lat_n3", m_write, 1);
    chk("lat_addr", m_addr, 32'h0800_1928);
    chk("lat_bc", 32'(m_bc), 1);
    drain("lat_drain");
    reg_rd(4'd4, r);
    chk("lat_wcnt", r, 1);
    for (int i = 0; i < 6; i++) begin
      send(tv[i].x, tv[i].y, tv[i].c, 20, ok);
      chk("tbl_accept", ok, 1);
      if (tv[i].drop) exp_drop++;
      else begin
        exp_q.push_back('{tv[i].ea, tv[i].c});
        exp_pts++;
      end
      drain("tbl_drain");
    end
    reg_rd(4'd3, r);
    chk("tbl_drops", 32'(r[31:16]), exp_drop);
    reg_rd(4'd4, r);
    chk("tbl_wcnt", r, exp_pts);
    force_wait = 1;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      send(i, 1, 32'hA000_0000 + i, 3, ok);
      if (ok) begin
        model_push(i, 1, 32'hA000_0000 + i);
        accepted++;
      end
    end
    chk("fifo_accepted", accepted, 17);
    chk("fifo_ready_low", p_ready, 0);
    force_wait = 0;
    for (int i = accepted; i < 20; i++) begin
      send(i, 1, 32'hA000_0000 + i, 100, ok);
      chk("fifo_late_accept", ok, 1);
      model_push(i, 1, 32'hA000_0000 + i);
    end
    drain("fifo_drain");
    reg_rd(4'd1, r);
    reg_wr(4'd1, 32'hFFFF_FFFF);
    clr_base = model_base; clr_col = 32'hFFFF_FFFF; clr_beats = 0; clr_active = 1;
    reg_wr(4'd2, 32'h1);
    for (int i = 0; i < 300 && clr_beats < 20; i++) begin
      @(posedge clk); #1;
    end
    force_wait = 1;
    repeat (5) @(posedge clk);
    #1 force_wait = 0;
    chk("clr_stall_beats", clr_beats, 20);
    send(3, 3, 32'h0BAD_F00D, 20, ok);
    chk("clr_pt_accept", ok, 1);
    model_push(3, 3, 32'h0BAD_F00D);
    reg_wr(4'd2, 32'h1);
    reg_rd(4'd3, r);
    chk("clr_status_run", 32'(r[1:0]), 3);
    for (int i = 0; i < 20000 && clr_beats < CLR_TOTAL; i++) begin
      @(posedge clk); #1;
    end
    chk("clr_total", clr_beats, CLR_TOTAL);
    clr_active = 0;
    drain("clr_drain");
    chk("clr_no_extra", clr_beats, CLR_TOTAL);
    reg_rd(4'd3, r);
    chk("clr_status_done", 32'(r[1:0]), 0);
    reg_rd(4'd4, r);
    chk("clr_wcnt", r, exp_pts);
    reg_wr(4'd0, 32'h1000_0000);
    model_base = 32'h1000_0000;
    send(3, 4, 32'h0000_0042, 20, ok);
    chk("base_accept", ok, 1);
    exp_q.push_back('{32'h1000_320C, 32'h0000_0042});
    exp_pts++;
    drain("base_drain");
    clr_base = model_base; clr_beats = 0; clr_active = 1;
    reg_wr(4'd2, 32'h1);
    for (int i = 0; i < 300 && clr_beats < 30; i++) begin
      @(posedge clk); #1;
    end
    send(1, 1, 32'h1, 5, ok);
    send(2, 1, 32'h2, 5, ok);
    rst = 1;
    clr_active = 0;
    @(posedge clk); #1;
    chk("rst_mid_write", m_write, 0);
    chk("rst_mid_ready", p_ready, 1);
    chk("rst_mid_busy", busy, 0);
    rst = 0;
    model_base = 32'h0800_0000; exp_pts = 0; exp_drop = 0;
    reg_rd(4'd0, r);
    chk("rst_mid_base", r, 32'h0800_0000);
    reg_rd(4'd1, r);
    chk("rst_mid_col", r, 0);
    reg_rd(4'd3, r);
    chk("rst_mid_status", r, 0);
    accepted = beats_total;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mid_fifo_empty", beats_total, accepted);
    rand_wait = 1;
    for (int i = 0; i < 40; i++) begin
      int x, y;
      logic [31:0] c;
      x = ($urandom_range(0, 7) == 0) ? $urandom_range(800, 1023) : $urandom_range(0, 799);
      y = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
      c = $urandom;
      send(x, y, c, 100, ok);
      chk("rand_accept", ok, 1);
      if (ok) model_push(x, y, c);
    end
    drain("rand_drain");
    rand_wait = 0;
    reg_rd(4'd4, r);
    chk("rand_wcnt", r, exp_pts);
    reg_rd(4'd3, r);
    chk("rand_drops", 32'(r[31:16]), exp_drop);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ltm_frame_writer.md
# ltm_frame_writer

Avalon-MM write master that fills the SDRAM LTM frame buffer, upstream of the LTM read-out controller that scans the same buffer to the panel. It accepts drawn points (x, y, colour) from the touch/stroke logic and writes each one to `base + (y*LTM_width + x)*4`. On command it burst-clears the whole 800×480 frame to a programmable colour. Software controls it through a small Avalon-MM slave.

## Interface
Parameters:
- `ADDRESS_BASE`, 32'h0800_0000: reset value of the frame base register.
- `LTM_width`, 800: pixels per line.
- `LTM_height`, 480: lines per frame.
- `WR_BURST`, 64: clear burst length in words. `LTM_width*LTM_height` must be divisible by it.
- `CMD_FIFO_DEPTH`, 16: point FIFO depth. Power of two.

Ports:
- `csi_clockreset_clk` in 1: the only clock.
- `csi_clockreset_reset` in 1: reset, synchronous, active-high.
- `avm_m1_address` out 32: write word address (byte address).
- `avm_m1_write` out 1: write request.
- `avm_m1_writedata` out 32: pixel data.
- `avm_m1_byteenable` out 4: constant 4'b1111.
- `avm_m1_burstcount` out 10: 1 for point writes, `WR_BURST` for clear.
- `avm_m1_waitrequest` in 1: slave stall.
- `avs_s1_address` in 4: register index.
- `avs_s1_write` in 1: register write strobe.
- `avs_s1_writedata` in 32: register write data.
- `avs_s1_read` in 1: register read strobe.
- `avs_s1_readdata` out 32: registered read data.
- `avm_m1_export_iPtValid` in 1: point valid.
- `avm_m1_export_iPtX` in 10: point x.
- `avm_m1_export_iPtY` in 10: point y.
- `avm_m1_export_iPtColor` in 32: point colour.
- `avm_m1_export_oPtReady` out 1: point FIFO not full.
- `avm_m1_export_oBusy` out 1: FSM not in IDLE.

## Operation
Registers:
- Reg 0: frame base, R/W.
- Reg 1: clear colour, R/W.
- Reg 2: control. Writing bit0=1 sets `clr_pend`. The bit self-clears and reads 0. Writing 1 while a clear is pending or running is ignored.
- Reg 3: status.
  - bit0: busy.
  - bit1: `clr_pend` or clear running.
  - [31:16]: dropped-point count.
- Reg 4: points-written count, RO, wraps at 2^32.
- Other indices read 0; writes to them are ignored.

Point path:
- A handshake occurs when `iPtValid & oPtReady`. {x, y, colour} is pushed into the FIFO.
- `oPtReady = !full`.

FSM states:
- IDLE:
  - If `clr_pend`: latch base and colour, clear `clr_pend`, burst index = 0, go to CLR_WR.
  - Else if the FIFO is not empty: pop, go to PT_ADDR.
- PT_ADDR: register `(y*LTM_width + x) << 2` (19-bit product, zero-extended) plus the base latched at pop. Go to PT_WR.
- PT_WR: drive `write=1`, burstcount=1. On `!waitrequest`, increment reg 4 and go to IDLE.
- CLR_WR:
  - Drive `write=1`, address = base + burst index × `WR_BURST`×4, burstcount=`WR_BURST`, data = clear colour.
  - Each `!waitrequest` cycle accepts one beat.
  - After the last beat, increment the burst index. If it reaches `LTM_width*LTM_height/WR_BURST` (6000 by default), go to IDLE; otherwise start the next burst in the next cycle.

Priority and ordering:
- Clear has priority only at IDLE.
- Points arriving during a clear queue in the FIFO and are written after the clear completes.
- A base-register write takes effect at the next operation start.

Reset:
- Reset mid-operation drops `avm_m1_write` on the next edge, even mid-burst.
- It empties the FIFO, clears `clr_pend`, and returns all registers to reset values.

## Timing
Reset values:
- `avm_m1_write`, `avm_m1_address`, `avm_m1_writedata`, `avs_s1_readdata`, `oBusy`: 0.
- `avm_m1_burstcount`: 1.
- `oPtReady`: 1.
- base = `ADDRESS_BASE`; colour and counters: 0.

Slave port:
- Read data is valid 1 cycle after `avs_s1_read`.
- A simultaneous read and write of the same register returns the old value.

Point latency:
- A point accepted at cycle N into an empty FIFO, with the FSM in IDLE, produces `avm_m1_write=1` at N+3.

Master-side stall rules:
- While `waitrequest=1`, address, burstcount, data and write stay stable.
- Burst beats are contiguous unless stalled.

FIFO boundaries:
- A simultaneous push and pop when full is not allowed, because ready is low.
- A simultaneous push and pop when not full keeps the count unchanged.

## Configuration
`LTM_WRITER_BOUNDS_CHECK_EN`
- Defined: points with x ≥ `LTM_width` or y ≥ `LTM_height` are popped and discarded with no bus write, and the drop count increments, saturating at 16'hFFFF.
- Undefined: no check, the address is computed unconditionally, and status[31:16] reads 0.

## Structure
- Package `ltm_writer_pkg`:
  - FSM state enum (IDLE, PT_ADDR, PT_WR, CLR_WR).
  - Register index constants.
  - Point struct {x, y, colour}.
- Sub-module `ltm_pt_fifo`: single-clock synchronous FIFO, `CMD_FIFO_DEPTH` × 52 bits, with full/empty flags.

## Test plan
- Base 0x0800_0000, point (10, 2, 0x00FF0000) → one write: address 0x0800_1928, burstcount 1, data 0x00FF0000. Reg 4 becomes 1.
- Reg1 = 0xFFFFFFFF, reg2 = 1 → 6000 bursts of 64 beats; first address 0x0800_0000, last 0x0817_6F00. Reg 3 bit1 returns to 0; reg 4 unchanged.
- `waitrequest` high for 5 cycles during beat 20 of a clear → address, data and write stable; exactly 64 beats still counted.
- `waitrequest` held high with 20 points offered → `oPtReady` low once the FIFO holds 16; after release, all accepted points are written in order.
- Point (800, 0): with macro → no write, status[31:16] = 1. Without macro → write to 0x0800_0C80.
- Reset asserted mid-clear → `avm_m1_write` = 0 next cycle, reg0 reads 0x0800_0000, FIFO empty, `oPtReady` = 1.
